// File: rtl/id_instr_queue_pkg.sv
// -----------------------------------------------------------------------------
// common
//   Shared types for the fetch -> decode hand-off.
//   - instruction_type    : raw fetched instruction word
//   - branch_predict_type : prediction info produced by fetch
//   - id_queue_entry_t    : one slot of the decode-input queue
//   - ID_QUEUE_DEPTH      : default number of queue entries
//   The entry layout is fixed at ID_ILEN/ID_XLEN bits. The queue resizes its
//   port values into these fields, so queue XLEN/ILEN should match them.
// -----------------------------------------------------------------------------
package common;

  localparam int ID_QUEUE_DEPTH = 4;
  localparam int ID_XLEN        = 32;
  localparam int ID_ILEN        = 32;

  typedef logic [ID_ILEN-1:0] instruction_type;

  typedef struct packed {
    logic               valid;
    logic               taken;
    logic [ID_XLEN-1:0] target;
  } branch_predict_type;

  typedef struct packed {
    instruction_type    instruction;
    logic [ID_XLEN-1:0] pc;
    branch_predict_type branch;
  } id_queue_entry_t;

endpackage

// File: rtl/id_instr_queue_ptr.sv
// -----------------------------------------------------------------------------
// id_queue_ptr
//   Wrap-around pointer for the decode-input queue. The queue depth is a power
//   of two, so the natural binary rollover gives the wrap for free.
//   Ports:
//     clk   - clock
//     rstn  - synchronous active-low reset (pointer -> 0)
//     clear - synchronous clear (pointer -> 0); has priority over inc
//     inc   - advance pointer by one
//     ptr   - current pointer value
// -----------------------------------------------------------------------------
module id_queue_ptr #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + WIDTH'(1);
    end
  end

endmodule

// File: rtl/id_instr_queue.sv
// -----------------------------------------------------------------------------
// id_instr_queue
//   DEPTH-entry FIFO between fetch and the ID stage with valid/ready on both
//   sides. Absorbs decode stalls; a flush (mispredict redirect) drops all
//   queued entries.
//   Ports:
//     clk, rstn              - clock, synchronous active-low reset
//     flush                  - discard all entries (ignores same-cycle push/pop)
//     in_valid / in_ready    - fetch-side handshake
//     in_instruction/pc/branch - entry presented by fetch
//     out_valid / out_ready  - decode-side handshake
//     out_instruction/pc/branch - head entry (don't care while out_valid=0)
//     count, full, empty     - occupancy status
//   Optional feature macro: ID_QUEUE_BYPASS_EN
//     When defined, an empty queue forwards in_* straight to out_* in the same
//     cycle; if decode takes it, nothing is stored.
// -----------------------------------------------------------------------------
module id_instr_queue
  import common::*;
#(
  parameter int DEPTH = ID_QUEUE_DEPTH,
  parameter int XLEN  = 32,
  parameter int ILEN  = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ILEN-1:0]            in_instruction,
  input  logic [XLEN-1:0]            in_pc,
  input  branch_predict_type         in_branch,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ILEN-1:0]            out_instruction,
  output logic [XLEN-1:0]            out_pc,
  output branch_predict_type         out_branch,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  id_queue_entry_t mem [DEPTH];

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  id_queue_entry_t in_entry;
  id_queue_entry_t out_entry;
  logic            push;
  logic            pop;
  logic            passthru;
  logic            wr_en;
  logic            rd_en;

  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Handshake and head selection. in_ready deliberately ignores out_ready:
  // a full queue refuses a push even if decode pops in the same cycle.
  // passthru marks an entry that goes straight from fetch to decode while
  // the queue is empty, so it must neither be stored nor advance rd_ptr.
  always_comb begin
    in_entry  = '{instruction: ID_ILEN'(in_instruction),
                  pc:          ID_XLEN'(in_pc),
                  branch:      in_branch};
    in_ready  = !full;
    out_valid = !empty;
    out_entry = mem[rd_ptr];
    passthru  = 1'b0;
`ifdef ID_QUEUE_BYPASS_EN
    if (empty && !flush) begin
      in_ready  = 1'b1;
      out_valid = in_valid;
      out_entry = in_entry;
      passthru  = in_valid && out_ready;
    end
`endif
    push  = in_valid && in_ready;
    pop   = out_valid && out_ready;
    wr_en = push && !passthru && !flush;
    rd_en = pop && !passthru && !flush;
  end

  assign out_instruction = ILEN'(out_entry.instruction);
  assign out_pc          = XLEN'(out_entry.pc);
  assign out_branch      = out_entry.branch;

  id_queue_ptr #(.WIDTH(PW)) u_wr_ptr (
    .clk   (clk),
    .rstn  (rstn),
    .clear (flush),
    .inc   (wr_en),
    .ptr   (wr_ptr)
  );

  id_queue_ptr #(.WIDTH(PW)) u_rd_ptr (
    .clk   (clk),
    .rstn  (rstn),
    .clear (flush),
    .inc   (rd_en),
    .ptr   (rd_ptr)
  );

  // Occupancy: simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is never cleared; stale slots are simply unreachable.
  always_ff @(posedge clk) begin
    if (rstn && wr_en) begin
      mem[wr_ptr] <= in_entry;
    end
  end

endmodule

// File: tb/tb_id_instr_queue.sv
// -----------------------------------------------------------------------------
// tb_id_instr_queue
//   Self-checking bench for id_instr_queue (DEPTH=4). Stimulus pushes the
//   expected entry into a scoreboard queue when fetch's push is accepted; a
//   monitor pops and compares whenever decode consumes the head.
//   Honours ID_QUEUE_BYPASS_EN for the bypass-specific directed cases.
// -----------------------------------------------------------------------------
module tb_id_instr_queue;
  import common::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic               clk;
  logic               rstn;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_instruction;
  logic [31:0]        in_pc;
  branch_predict_type in_branch;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_instruction;
  logic [31:0]        out_pc;
  branch_predict_type out_branch;
  logic [CW-1:0]      count;
  logic               full;
  logic               empty;

  int checks   = 0;
  int failures = 0;

  id_queue_entry_t expq[$];

  id_instr_queue #(.DEPTH(DEPTH), .XLEN(32), .ILEN(32)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instruction  (in_instruction),
    .in_pc           (in_pc),
    .in_branch       (in_branch),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .out_branch      (out_branch),
    .count           (count),
    .full            (full),
    .empty           (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Every pc gets a distinct, hand-derivable instruction and prediction.
  function automatic id_queue_entry_t makeEntry(input logic [31:0] pc);
    id_queue_entry_t e;
    e.instruction   = pc ^ 32'hDEAD_0000;
    e.pc            = pc;
    e.branch.valid  = pc[2];
    e.branch.taken  = pc[3];
    e.branch.target = pc + 32'd8;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // One cycle: drive after the posedge, then at the negedge record whether
  // the push will be accepted at the coming edge.
  task automatic applyStimulus(input logic v, input logic [31:0] pc,
                               input logic ordy, input logic fl);
    id_queue_entry_t e;
    e = makeEntry(pc);
    @(posedge clk);
    #1;
    in_valid       = v;
    in_instruction = e.instruction;
    in_pc          = e.pc;
    in_branch      = e.branch;
    out_ready      = ordy;
    flush          = fl;
    @(negedge clk);
    if (fl) begin
      expq.delete();
    end else if (rstn && v && in_ready) begin
      expq.push_back(e);
    end
  endtask

  // Monitor: compares every consumed head against the scoreboard and watches
  // occupancy invariants.
  initial begin
    id_queue_entry_t exp_e;
    forever begin
      @(negedge clk);
      #1;
      if (rstn) begin
        if (count > CW'(DEPTH)) begin
          failures++;
          $display("[TB] FAIL count_bound: got %0d expected <= %0d", count, DEPTH);
        end
        if (full && in_ready) begin
          failures++;
          $display("[TB] FAIL push_when_full: got in_ready=1 expected 0");
        end
`ifndef ID_QUEUE_BYPASS_EN
        if (empty && out_valid) begin
          failures++;
          $display("[TB] FAIL pop_when_empty: got out_valid=1 expected 0");
        end
`endif
        if (out_valid && out_ready && !flush) begin
          checks++;
          if (expq.size() == 0) begin
            failures++;
            $display("[TB] FAIL pop_entry: got pc 0x%0h expected no pop", out_pc);
          end else begin
            exp_e = expq.pop_front();
            if (out_pc !== exp_e.pc || out_instruction !== exp_e.instruction ||
                out_branch !== exp_e.branch) begin
              failures++;
              $display("[TB] FAIL pop_entry: got pc 0x%0h instr 0x%0h expected pc 0x%0h instr 0x%0h",
                       out_pc, out_instruction, exp_e.pc, exp_e.instruction);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int occ;
    int pushed;
    int iter;
    logic do_push;
    logic do_pop;

    rstn = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_instruction = '0;
    in_pc = '0;
    in_branch = '0;
    out_ready = 1'b0;

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_empty",     32'(empty),     32'd1);
    checkOutput("reset_full",      32'(full),      32'd0);
    checkOutput("reset_count",     32'(count),     32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Fill to DEPTH with decode stalled, then drain in order
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h100 + 32'(4*i), 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("fill_full",     32'(full),     32'd1);
    checkOutput("fill_in_ready", 32'(in_ready), 32'd0);
    checkOutput("fill_count",    32'(count),    32'd4);
    checkOutput("fill_head_pc",  out_pc,        32'h100);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("drain_empty", 32'(empty), 32'd1);
    checkOutput("drain_count", 32'(count), 32'd0);

    // Wrap-around: 10 entries, random interleave, occupancy at most 3
    void'($urandom(32'h1234));
    occ = 0;
    pushed = 0;
    iter = 0;
    while ((pushed < 10 || occ > 0) && iter < 200) begin
      do_push = (pushed < 10) && (occ < 3) && (occ == 0 || $urandom_range(0, 1) == 1);
      do_pop  = (occ > 0) && ($urandom_range(0, 1) == 1);
      applyStimulus(do_push, 32'h1000 + 32'(4*pushed), do_pop, 1'b0);
      checkOutput("wrap_count", 32'(count), 32'(occ));
      if (do_push) pushed++;
      occ = occ + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
      iter++;
    end
    checkOutput("wrap_done", 32'(iter < 200), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("wrap_empty", 32'(empty), 32'd1);

    // Full with simultaneous pop: pop happens, push refused
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h400 + 32'(4*i), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h410, 1'b1, 1'b0);
    checkOutput("fullpop_in_ready", 32'(in_ready), 32'd0);
    checkOutput("fullpop_count",    32'(count),    32'd4);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("fullpop_count_after", 32'(count), 32'd3);
    checkOutput("fullpop_head_pc",     out_pc,     32'h404);

    // Flush overrides same-cycle push and pop
    applyStimulus(1'b1, 32'h500, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_empty", 32'(empty), 32'd1);
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("post_flush_pc",    out_pc,          32'h200);
    checkOutput("post_flush_count", 32'(count),      32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

`ifdef ID_QUEUE_BYPASS_EN
    // Bypass: same-cycle pass-through when decode is ready
    applyStimulus(1'b1, 32'h300, 1'b1, 1'b0);
    checkOutput("bypass_out_valid", 32'(out_valid), 32'd1);
    checkOutput("bypass_out_pc",    out_pc,         32'h300);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("bypass_count", 32'(count), 32'd0);
    applyStimulus(1'b1, 32'h304, 1'b0, 1'b0);
    checkOutput("bypass_stall_valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("bypass_stall_count", 32'(count), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
`else
    // No bypass: an entry pushed into an empty queue appears one cycle later
    applyStimulus(1'b1, 32'h300, 1'b1, 1'b0);
    checkOutput("latency_same_cycle_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("latency_next_valid", 32'(out_valid), 32'd1);
    checkOutput("latency_next_pc",    out_pc,         32'h300);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
`endif
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("final_empty",      32'(empty),       32'd1);
    checkOutput("scoreboard_drain", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
